iob_axi_bridge: RTL

IOB_AXI_BRIDGE -- requirements
Module: iob_axi_bridge

---
 rtl/iob_axi_pkg.sv | 33 +++
 rtl/iob_axi_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iob_axi_pkg.sv
// Shared definitions for the native-to-AXI4 bridge: FSM encoding and fixed AXI attributes.
package iob_axi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_CACHE_W = 4;
  localparam int unsigned AXI_PROT_W  = 3;
  localparam int unsigned AXI_QOS_W   = 4;
  localparam int unsigned AXI_RESP_W  = 2;

  localparam logic [AXI_LEN_W-1:0]   AXI_LEN_SINGLE = '0;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic                   AXI_LOCK_NORM  = 1'b0;
  localparam logic [AXI_CACHE_W-1:0] AXI_CACHE      = 4'b0011;
  localparam logic [AXI_PROT_W-1:0]  AXI_PROT       = 3'b010;
  localparam logic [AXI_QOS_W-1:0]   AXI_QOS        = '0;

  // AXI size field for a full-width beat of the given byte count.
  function automatic logic [AXI_SIZE_W-1:0] axi_size(input int unsigned bytes);
    return AXI_SIZE_W'($clog2(bytes));
  endfunction

endpackage

// File: rtl/iob_axi_bridge.sv
// Single-beat native (valid/ready) to AXI4 master bridge.
// Optional sticky error flag on non-OKAY responses when IOB_AXI_BRIDGE_ERR_EN is defined.
module iob_axi_bridge
  import iob_axi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AXI_ID_W = 1,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   valid,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    wstrb,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,

  output logic [AXI_ID_W-1:0]    m_axi_awid,
  output logic [ADDR_W-1:0]      m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]   m_axi_awlen,
  output logic [AXI_SIZE_W-1:0]  m_axi_awsize,
  output logic [AXI_BURST_W-1:0] m_axi_awburst,
  output logic                   m_axi_awlock,
  output logic [AXI_CACHE_W-1:0] m_axi_awcache,
  output logic [AXI_PROT_W-1:0]  m_axi_awprot,
  output logic [AXI_QOS_W-1:0]   m_axi_awqos,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,

  output logic [DATA_W-1:0]      m_axi_wdata,
  output logic [DATA_W/8-1:0]    m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,

  input  logic [AXI_ID_W-1:0]    m_axi_bid,
  input  logic [AXI_RESP_W-1:0]  m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,

  output logic [AXI_ID_W-1:0]    m_axi_arid,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic [AXI_LEN_W-1:0]   m_axi_arlen,
  output logic [AXI_SIZE_W-1:0]  m_axi_arsize,
  output logic [AXI_BURST_W-1:0] m_axi_arburst,
  output logic                   m_axi_arlock,
  output logic [AXI_CACHE_W-1:0] m_axi_arcache,
  output logic [AXI_PROT_W-1:0]  m_axi_arprot,
  output logic [AXI_QOS_W-1:0]   m_axi_arqos,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,

  input  logic [AXI_ID_W-1:0]    m_axi_rid,
  input  logic [DATA_W-1:0]      m_axi_rdata,
  input  logic [AXI_RESP_W-1:0]  m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
`ifdef IOB_AXI_BRIDGE_ERR_EN
  , output logic                 err
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [AXI_SIZE_W-1:0] BEAT_SIZE = axi_size(STRB_W);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic aw_done;
  logic w_done;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign b_hs  = m_axi_bvalid  && m_axi_bready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rvalid  && m_axi_rready;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  // Payloads come straight from the request latch, so they stay put while valid is high.
  assign m_axi_awid    = AXI_ID_W'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = AXI_LEN_SINGLE;
  assign m_axi_awsize  = BEAT_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = AXI_LOCK_NORM;
  assign m_axi_awcache = AXI_CACHE;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_awqos   = AXI_QOS;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_arid    = AXI_ID_W'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = AXI_LEN_SINGLE;
  assign m_axi_arsize  = BEAT_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = AXI_LOCK_NORM;
  assign m_axi_arcache = AXI_CACHE;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_arqos   = AXI_QOS;

  // Transaction FSM; every handshake/control output is a register updated on transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata         <= '0;
      ready         <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && !ready) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            if (|wstrb) begin
              state         <= WADDR;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= RADDR;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        WADDR: begin
          if (aw_hs) m_axi_awvalid <= 1'b0;
          if (w_hs)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state        <= WRESP;
            m_axi_bready <= 1'b1;
          end
        end
        WRESP: begin
          if (b_hs) begin
            state        <= DONE;
            m_axi_bready <= 1'b0;
            ready        <= 1'b1;
          end
        end
        RADDR: begin
          if (ar_hs) begin
            state         <= RDATA;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (r_hs) begin
            state        <= DONE;
            m_axi_rready <= 1'b0;
            rdata        <= m_axi_rdata;
            ready        <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IOB_AXI_BRIDGE_ERR_EN
  // Sticky error: any non-OKAY response seen since the last reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((b_hs && (|m_axi_bresp)) || (r_hs && (|m_axi_rresp))) begin
      err <= 1'b1;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};
`else
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_bresp, m_axi_rresp};
`endif

endmodule
